// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: opcode map, end-marker word and FSM states shared by the program loader.
// Also supplies fallback values for the `PRGMEM_ADDR_WIDTH / `INSTR_WIDTH width macros.
`ifndef PRGMEM_ADDR_WIDTH
`define PRGMEM_ADDR_WIDTH 8
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 4
`endif

package prog_loader_pkg;

  localparam logic [2:0] OP_PTR_INC   = 3'b000;
  localparam logic [2:0] OP_PTR_DEC   = 3'b001;
  localparam logic [2:0] OP_VAL_INC   = 3'b010;
  localparam logic [2:0] OP_VAL_DEC   = 3'b011;
  localparam logic [2:0] OP_OUTPUT    = 3'b100;
  localparam logic [2:0] OP_INPUT     = 3'b101;
  localparam logic [2:0] OP_LOOP_OPEN = 3'b110;
  localparam logic [2:0] OP_LOOP_END  = 3'b111;

  // Sliced down to INSTR_WIDTH by the loader; wide enough for any sane word size.
  localparam int         END_MARKER_MAX_WIDTH = 64;
  localparam logic [END_MARKER_MAX_WIDTH-1:0] END_MARKER = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TERM,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: character stream in, program-memory write port out.
// The slave modport is the loader; the master modport is the character source / memory side.
interface prog_loader_if #(
  parameter int ADDR_WIDTH  = `PRGMEM_ADDR_WIDTH,
  parameter int INSTR_WIDTH = `INSTR_WIDTH
);

  logic                   i_char_valid;
  logic [7:0]             i_char;
  logic                   o_char_ready;
  logic                   o_prgmem_in;
  logic [ADDR_WIDTH-1:0]  o_prgmem_addr;
  logic [INSTR_WIDTH-1:0] o_prgmem_data;

  modport master (
    output i_char_valid,
    output i_char,
    input  o_char_ready,
    input  o_prgmem_in,
    input  o_prgmem_addr,
    input  o_prgmem_data
  );

  modport slave (
    input  i_char_valid,
    input  i_char,
    output o_char_ready,
    output o_prgmem_in,
    output o_prgmem_addr,
    output o_prgmem_data
  );

endinterface

// File: rtl/prog_loader_bf_char_decode.sv
// bf_char_decode: combinational map from an ASCII byte to {is_cmd, opcode}.
// Anything that is not one of the eight brainhack commands reports is_cmd = 0.
module bf_char_decode (
  input  logic [7:0] char_code,
  output logic       is_cmd,
  output logic [2:0] opcode
);

  import prog_loader_pkg::*;

  always_comb begin
    is_cmd = 1'b1;
    opcode = OP_PTR_INC;
    case (char_code)
      8'h3E:   opcode = OP_PTR_INC;
      8'h3C:   opcode = OP_PTR_DEC;
      8'h2B:   opcode = OP_VAL_INC;
      8'h2D:   opcode = OP_VAL_DEC;
      8'h2E:   opcode = OP_OUTPUT;
      8'h2C:   opcode = OP_INPUT;
      8'h5B:   opcode = OP_LOOP_OPEN;
      8'h5D:   opcode = OP_LOOP_END;
      default: is_cmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams ASCII brainhack source into program memory, then appends an end marker.
// Define PROG_LOADER_BRACKET_CHECK_EN to reject programs with unbalanced '[' / ']'.
module prog_loader #(
  parameter int ADDR_WIDTH  = `PRGMEM_ADDR_WIDTH,
  parameter int INSTR_WIDTH = `INSTR_WIDTH,
  parameter int DEPTH_WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_start,
  prog_loader_if.slave      bus,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_WIDTH:0] o_length
);

  import prog_loader_pkg::*;

  if (INSTR_WIDTH < 3 || DEPTH_WIDTH < 1) begin : g_bad_params
    $error("prog_loader: INSTR_WIDTH must be >= 3 and DEPTH_WIDTH >= 1");
  end

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH:0]    length;
  logic [INSTR_WIDTH-1:0] word;
  logic                   is_cmd;
  logic [2:0]             opcode;
  logic                   consume;
  logic                   is_null;
  logic                   addr_last;
  logic                   start_ok;
  logic                   reject;
  logic                   cmd_write;

  bf_char_decode u_decode (
    .char_code (bus.i_char),
    .is_cmd    (is_cmd),
    .opcode    (opcode)
  );

  assign consume   = (state == ST_LOAD) && bus.i_char_valid;
  assign is_null   = (bus.i_char == 8'h00);
  assign addr_last = &addr;
  assign start_ok  = i_start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

`ifdef PROG_LOADER_BRACKET_CHECK_EN
  logic [DEPTH_WIDTH-1:0] depth;
  logic                   open_b;
  logic                   close_b;

  assign open_b  = is_cmd && (opcode == OP_LOOP_OPEN);
  assign close_b = is_cmd && (opcode == OP_LOOP_END);
  // An offending byte is consumed but never written; the FSM parks in ERROR.
  assign reject  = consume && ((close_b && depth == '0) ||
                               (open_b && &depth) ||
                               (is_null && depth != '0));

  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      depth <= '0;
    end else if (cmd_write && open_b) begin
      depth <= depth + DEPTH_WIDTH'(1);
    end else if (cmd_write && close_b) begin
      depth <= depth - DEPTH_WIDTH'(1);
    end
  end
`else
  assign reject = 1'b0;
`endif

  assign cmd_write = consume && is_cmd && !reject;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        // The last free slot takes the command, leaving no room for the end marker.
        if (consume) begin
          if (reject)                    state_next = ST_ERROR;
          else if (is_null)              state_next = ST_TERM;
          else if (is_cmd && addr_last)  state_next = ST_ERROR;
        end
      end
      ST_TERM: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_char_ready = (state == ST_LOAD);
    bus.o_prgmem_in  = 1'b0;
    word             = '0;
    o_cpu_hold       = (state == ST_LOAD) || (state == ST_TERM);
    o_done           = (state == ST_DONE);
    o_error          = (state == ST_ERROR);
    if (state == ST_TERM) begin
      bus.o_prgmem_in = 1'b1;
      word            = END_MARKER[INSTR_WIDTH-1:0];
    end else if (cmd_write) begin
      bus.o_prgmem_in = 1'b1;
      word[2:0]       = opcode;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      addr   <= '0;
      length <= '0;
    end else if (cmd_write) begin
      addr   <= addr + ADDR_WIDTH'(1);
      length <= length + (ADDR_WIDTH+1)'(1);
    end
  end

  assign bus.o_prgmem_addr = addr;
  assign bus.o_prgmem_data = word;
  assign o_length          = length;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed streams into an 8-bit-address loader and a 2-bit-address loader;
// every memory write is checked against a queue of expected {address, word} entries.
module tb_prog_loader;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  prog_loader_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(4)) bus_a ();
  prog_loader_if #(.ADDR_WIDTH(2), .INSTR_WIDTH(4)) bus_b ();

  logic       hold_a, done_a, error_a;
  logic [8:0] length_a;
  logic       hold_b, done_b, error_b;
  logic [2:0] length_b;

  logic [11:0] exp_a[$];
  logic [5:0]  exp_b[$];
  int          model_addr_a = 0;
  int          model_addr_b = 0;

  always #5 clock = ~clock;

  prog_loader #(.ADDR_WIDTH(8), .INSTR_WIDTH(4), .DEPTH_WIDTH(8)) dut_a (
    .clock(clock), .reset(reset), .i_start(start_a), .bus(bus_a),
    .o_cpu_hold(hold_a), .o_done(done_a), .o_error(error_a), .o_length(length_a)
  );

  prog_loader #(.ADDR_WIDTH(2), .INSTR_WIDTH(4), .DEPTH_WIDTH(8)) dut_b (
    .clock(clock), .reset(reset), .i_start(start_b), .bus(bus_b),
    .o_cpu_hold(hold_b), .o_done(done_b), .o_error(error_b), .o_length(length_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference opcode table, written out independently of the RTL decoder.
  function automatic logic [3:0] encode_char(input logic [7:0] ch);
    case (ch)
      8'h3E:   return 4'b0000;
      8'h3C:   return 4'b0001;
      8'h2B:   return 4'b0010;
      8'h2D:   return 4'b0011;
      8'h2E:   return 4'b0100;
      8'h2C:   return 4'b0101;
      8'h5B:   return 4'b0110;
      8'h5D:   return 4'b0111;
      default: return 4'bxxxx;
    endcase
  endfunction

  always @(negedge clock) begin
    logic [11:0] want_a;
    logic [5:0]  want_b;
    if (bus_a.o_prgmem_in === 1'b1) begin
      want_a = 'x;
      if (exp_a.size() > 0) want_a = exp_a.pop_front();
      checkOutput("write_a", {bus_a.o_prgmem_addr, bus_a.o_prgmem_data}, want_a);
    end
    if (bus_b.o_prgmem_in === 1'b1) begin
      want_b = 'x;
      if (exp_b.size() > 0) want_b = exp_b.pop_front();
      checkOutput("write_b", {bus_b.o_prgmem_addr, bus_b.o_prgmem_data}, want_b);
    end
  end

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  task automatic set_char(input bit on_b, input logic valid, input logic [7:0] ch);
    if (on_b) begin
      bus_b.i_char_valid = valid;
      bus_b.i_char       = ch;
    end else begin
      bus_a.i_char_valid = valid;
      bus_a.i_char       = ch;
    end
  endtask

  task automatic pulse_start(input bit on_b);
    if (on_b) begin
      start_b = 1'b1; model_addr_b = 0;
    end else begin
      start_a = 1'b1; model_addr_a = 0;
    end
    align();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic push_term(input bit on_b);
    if (on_b) exp_b.push_back({2'(model_addr_b), 4'hF});
    else      exp_a.push_back({8'(model_addr_a), 4'hF});
  endtask

  // Offers one byte until accepted (bounded), optionally idling one cycle afterwards.
  task automatic applyStimulus(input bit on_b, input logic [7:0] ch, input bit expect_write, input bit gap);
    bit consumed;
    logic ready;
    if (expect_write) begin
      if (on_b) begin
        exp_b.push_back({2'(model_addr_b), encode_char(ch)});
        model_addr_b++;
      end else begin
        exp_a.push_back({8'(model_addr_a), encode_char(ch)});
        model_addr_a++;
      end
    end
    set_char(on_b, 1'b1, ch);
    consumed = 1'b0;
    for (int n = 0; n < 20 && !consumed; n++) begin
      @(negedge clock);
      ready = on_b ? bus_b.o_char_ready : bus_a.o_char_ready;
      if (ready === 1'b1) consumed = 1'b1;
      align();
    end
    set_char(on_b, 1'b0, 8'h00);
    if (gap) align();
    checkOutput("consume", 32'(consumed), 32'd1);
  endtask

  task automatic checkStatus(input bit on_b, input int exp_len, input bit exp_done, input bit exp_err);
    repeat (2) align();
    @(negedge clock);
    if (on_b) begin
      checkOutput("done_b", done_b, exp_done);
      checkOutput("error_b", error_b, exp_err);
      checkOutput("hold_b", hold_b, 1'b0);
      checkOutput("length_b", length_b, exp_len);
      checkOutput("ready_b", bus_b.o_char_ready, 1'b0);
      checkOutput("drain_b", exp_b.size(), 0);
    end else begin
      checkOutput("done_a", done_a, exp_done);
      checkOutput("error_a", error_a, exp_err);
      checkOutput("hold_a", hold_a, 1'b0);
      checkOutput("length_a", length_a, exp_len);
      checkOutput("ready_a", bus_a.o_char_ready, 1'b0);
      checkOutput("drain_a", exp_a.size(), 0);
    end
    align();
  endtask

  initial begin
    set_char(1'b0, 1'b0, 8'h00);
    set_char(1'b1, 1'b0, 8'h00);
    repeat (3) align();
    @(negedge clock);
    checkOutput("rst_hold", hold_a, 1'b0);
    checkOutput("rst_ready", bus_a.o_char_ready, 1'b0);
    checkOutput("rst_wr", bus_a.o_prgmem_in, 1'b0);
    checkOutput("rst_length", length_a, 0);
    align();
    reset = 1'b0;
    align();

    $display("[TB] balanced loop \"+[-]\"");
    pulse_start(1'b0);
    @(negedge clock);
    checkOutput("load_hold", hold_a, 1'b1);
    checkOutput("load_ready", bus_a.o_char_ready, 1'b1);
    align();
    applyStimulus(1'b0, 8'h2B, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h5B, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h2D, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h5D, 1'b1, 1'b0);
    push_term(1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkStatus(1'b0, 4, 1'b1, 1'b0);

    $display("[TB] non-command bytes and ignored start");
    pulse_start(1'b0);
    applyStimulus(1'b0, 8'h61, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h2B, 1'b1, 1'b0);
    start_a = 1'b1;
    align();
    start_a = 1'b0;
    applyStimulus(1'b0, 8'h20, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h62, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h0A, 1'b0, 1'b0);
    push_term(1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkStatus(1'b0, 1, 1'b1, 1'b0);

    $display("[TB] gapped valid, five '>'");
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h3E, 1'b1, 1'b1);
    push_term(1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkStatus(1'b0, 5, 1'b1, 1'b0);

    $display("[TB] reset mid-load");
    pulse_start(1'b0);
    applyStimulus(1'b0, 8'h2B, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h2B, 1'b1, 1'b0);
    reset = 1'b1;
    align();
    @(negedge clock);
    checkOutput("mrst_hold", hold_a, 1'b0);
    checkOutput("mrst_ready", bus_a.o_char_ready, 1'b0);
    checkOutput("mrst_wr", bus_a.o_prgmem_in, 1'b0);
    checkOutput("mrst_addr", bus_a.o_prgmem_addr, 0);
    checkOutput("mrst_data", bus_a.o_prgmem_data, 0);
    checkOutput("mrst_length", length_a, 0);
    checkOutput("mrst_flags", {done_a, error_a}, 2'b00);
    align();
    reset = 1'b0;
    pulse_start(1'b0);
    applyStimulus(1'b0, 8'h2D, 1'b1, 1'b0);
    push_term(1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkStatus(1'b0, 1, 1'b1, 1'b0);

    $display("[TB] 2-bit address overflow");
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h2B, 1'b1, 1'b0);
    checkStatus(1'b1, 4, 1'b0, 1'b1);

`ifdef PROG_LOADER_BRACKET_CHECK_EN
    $display("[TB] bracket balance checking");
    pulse_start(1'b0);
    applyStimulus(1'b0, 8'h5D, 1'b0, 1'b0);
    checkStatus(1'b0, 0, 1'b0, 1'b1);
    pulse_start(1'b0);
    applyStimulus(1'b0, 8'h5B, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h5B, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkStatus(1'b0, 2, 1'b0, 1'b1);
`else
    $display("[TB] unchecked brackets");
    pulse_start(1'b0);
    applyStimulus(1'b0, 8'h5D, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h5B, 1'b1, 1'b0);
    push_term(1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkStatus(1'b0, 2, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default `prgmem_addr_width, program memory address width.
REQ-002 Parameter INSTR_WIDTH, default `instr_width, instruction word width; minimum 3.
REQ-003 Parameter DEPTH_WIDTH, default 8, loop-nesting counter width.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 i_start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERROR.
REQ-008 i_char_valid  input  1  source byte present on i_char.
REQ-009 i_char  input  8  ASCII source character.
REQ-010 o_char_ready  output  1  loader accepts i_char this cycle.
REQ-011 o_prgmem_in  output  1  program memory write enable.
REQ-012 o_prgmem_addr  output  ADDR_WIDTH  write address.
REQ-013 o_prgmem_data  output  INSTR_WIDTH  encoded instruction word.
REQ-014 o_cpu_hold  output  1  holds brainhack core in reset while high.
REQ-015 o_done  output  1  load finished successfully; level.
REQ-016 o_error  output  1  load aborted; level.
REQ-017 o_length  output  ADDR_WIDTH+1  instructions written, terminator excluded.

Function
REQ-018 States: IDLE, LOAD, TERM, DONE, ERROR; i_start moves IDLE/DONE/ERROR to LOAD, clears o_done, o_error, address, o_length and depth.
REQ-019 o_char_ready SHALL be high only in LOAD; a byte is consumed when i_char_valid and o_char_ready are both high.
REQ-020 Encoding (LSBs, upper bits zero): '>'=000, '<'=001, '+'=010, '-'=011, '.'=100, ','=101, '['=110, ']'=111.
REQ-021 Consumed command byte SHALL drive o_prgmem_in=1, current address and encoded word in the same cycle; address and o_length increment next edge.
REQ-022 Consumed non-command byte other than 0x00 SHALL be discarded, no write, no address change.
REQ-023 Consumed 0x00 SHALL move LOAD to TERM without a write.
REQ-024 TERM SHALL write the all-ones INSTR_WIDTH word (end marker) at the current address for exactly one cycle, then move to DONE.
REQ-025 Command consumed when address equals 2^ADDR_WIDTH-1 SHALL be written, then the loader SHALL go to ERROR (no room for terminator); no write after that.
REQ-026 o_cpu_hold SHALL be high in LOAD and TERM and low otherwise; o_done high only in DONE; o_error high only in ERROR.
REQ-027 i_start during LOAD or TERM SHALL be ignored.
REQ-028 o_prgmem_in SHALL be low in IDLE, DONE and ERROR.

Reset
REQ-029 Reset SHALL force IDLE, address 0, o_length 0, depth 0, all outputs 0, including mid-load; a partially written memory is left as is.

Configuration
REQ-030 Macro PROG_LOADER_BRACKET_CHECK_EN SHALL enable loop-balance checking.
REQ-031 With it: '[' increments depth, ']' decrements; ']' at depth 0, depth overflow past 2^DEPTH_WIDTH-1, or 0x00 with depth nonzero SHALL go to ERROR without writing the offending item.
REQ-032 Without it: no depth counter, brackets encoded like any command, 0x00 always goes to TERM.

Structure
REQ-033 Shared package holds opcode constants (8 commands), end-marker constant and the state enumeration.
REQ-034 One sub-module, bf_char_decode: combinational ASCII-to-{is_cmd, opcode}; FSM, counters and handshake stay in prog_loader.

Verification
REQ-035 Stream "+[-]" then 0x00 -> writes 010,110,011,111 at 0..3, all-ones at 4, o_length 4, o_done 1.
REQ-036 Stream "a+ b\n" then 0x00 -> only 010 written at 0, terminator at 1, o_length 1.
REQ-037 i_char_valid toggled every other cycle with ">" x5 -> exactly 5 writes, addresses 0..4, none duplicated.
REQ-038 With ADDR_WIDTH 2, stream "++++" -> 4 writes, then o_error 1, o_cpu_hold 0, no terminator.
REQ-039 With PROG_LOADER_BRACKET_CHECK_EN, stream "]" -> o_error 1, no write; "[[" then 0x00 -> o_error 1 after 2 writes.
REQ-040 Reset asserted after two consumed bytes -> next cycle all outputs 0, state IDLE; new i_start restarts at address 0.
